// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared types and default geometry for the Mandelbrot front end
package mandel_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int FRAC_DEF    = 16;
    localparam int DEPTH_W_DEF = 8;

    typedef logic signed [31:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_OUTPUT
    } sched_state_t;

endpackage

// File: rtl/coord_stepper.sv
// rtl/coord_stepper.sv - maps raster position to the complex plane by incremental stepping
module coord_stepper
    import mandel_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic   sysclk,
    input  logic   reset_n,
    input  logic   init,
    input  logic   next_x,
    input  logic   next_line,
    input  coord_t center_re,
    input  coord_t center_im,
    input  coord_t step,
    output coord_t re_c,
    output coord_t im_c
);

    localparam coord_t HALF_W = coord_t'(H_RES / 2);
    localparam coord_t HALF_H = coord_t'(V_RES / 2);

    coord_t step_q;
    coord_t re_left;
    coord_t re_acc;
    coord_t im_acc;
    coord_t re_left_n;
    coord_t im_top;

    // Products wrap to 32 bits; a huge step simply aliases rather than saturating.
    assign re_left_n = center_re - HALF_W * step;
    assign im_top    = center_im + HALF_H * step;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            step_q  <= '0;
            re_left <= '0;
            re_acc  <= '0;
            im_acc  <= '0;
        end else if (init) begin
            step_q  <= step;
            re_left <= re_left_n;
            re_acc  <= re_left_n;
            im_acc  <= im_top;
        end else if (next_x) begin
            re_acc  <= re_acc + step_q;
        end else if (next_line) begin
            re_acc  <= re_left;
            im_acc  <= im_acc - step_q;
        end
    end

    assign re_c = re_acc;
    assign im_c = im_acc;

endmodule

// File: rtl/pixel_scheduler.sv
// rtl/pixel_scheduler.sv - raster walker that feeds depth_calculator and streams its results
module pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int DEPTH_W = DEPTH_W_DEF
) (
    input  logic               sysclk,
    input  logic               reset_n,
    input  logic               enable,
    input  coord_t             center_re,
    input  coord_t             center_im,
    input  coord_t             step,
    output logic               calc_start,
    output logic [9:0]         calc_x,
    output logic [8:0]         calc_y,
    output coord_t             calc_re_c,
    output coord_t             calc_im_c,
    input  logic [DEPTH_W-1:0] calc_depth,
    input  logic               calc_done,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [DEPTH_W-1:0] pix_depth,
    output logic [9:0]         pix_x,
    output logic [8:0]         pix_y,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               frame_done,
    output logic               busy
);

    sched_state_t state, state_n;
    logic [9:0]   x;
    logic [8:0]   y;
    logic         done_q;
    logic         done_edge;
    logic         last_x;
    logic         last_y;
    logic         accept;
    logic         capture;
    logic         init;
    logic         next_x;
    logic         next_line;

    // A done level held over from the previous pixel must not count; only a fresh rise does.
    assign done_edge = calc_done & ~done_q;
    assign last_x    = (x == 10'(H_RES - 1));
    assign last_y    = (y == 9'(V_RES - 1));
    assign capture   = (state == ST_WAIT) & done_edge;
    assign accept    = (state == ST_OUTPUT) & pix_valid & pix_ready;

    always_comb begin
        state_n   = state;
        init      = 1'b0;
        next_x    = 1'b0;
        next_line = 1'b0;
        case (state)
            ST_IDLE:   if (enable) state_n = ST_SETUP;
            ST_SETUP: begin
                init    = 1'b1;
                state_n = ST_ISSUE;
            end
            ST_ISSUE:  state_n = ST_WAIT;
            ST_WAIT:   if (done_edge) state_n = ST_OUTPUT;
            ST_OUTPUT: begin
                if (accept) begin
                    if (!last_x) begin
                        next_x  = 1'b1;
                        state_n = ST_ISSUE;
                    end else if (!last_y) begin
                        next_line = 1'b1;
                        state_n   = ST_ISSUE;
                    end else begin
                        state_n = enable ? ST_SETUP : ST_IDLE;
                    end
                end
            end
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            done_q     <= 1'b0;
            pix_valid  <= 1'b0;
            pix_depth  <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            done_q     <= calc_done;
            frame_done <= 1'b0;
            if (init) begin
                x <= '0;
                y <= '0;
            end else if (next_x) begin
                x <= x + 10'd1;
            end else if (next_line) begin
                x <= '0;
                y <= y + 9'd1;
            end
            if (capture) begin
                pix_valid <= 1'b1;
                pix_depth <= calc_depth;
                pix_x     <= x;
                pix_y     <= y;
                pix_sof   <= (x == 10'd0) && (y == 9'd0);
                pix_eol   <= last_x;
            end else if (accept) begin
                pix_valid  <= 1'b0;
                frame_done <= last_x & last_y;
            end
        end
    end

    coord_stepper #(.H_RES(H_RES), .V_RES(V_RES)) u_coord_stepper (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .init      (init),
        .next_x    (next_x),
        .next_line (next_line),
        .center_re (center_re),
        .center_im (center_im),
        .step      (step),
        .re_c      (calc_re_c),
        .im_c      (calc_im_c)
    );

    assign calc_start = (state == ST_ISSUE);
    assign calc_x     = x;
    assign calc_y     = y;
    assign busy       = (state != ST_IDLE);

endmodule
